// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions used by the branch unit and the control-unit decoder.
package kgp_risc_pkg;

  // Condition selector driven by the control unit onto the branch unit.
  typedef enum logic [1:0] {
    FLAG_SEL_CARRY = 2'b00,
    FLAG_SEL_ZERO  = 2'b01,
    FLAG_SEL_SIGN  = 2'b10,
    FLAG_SEL_RSVD  = 2'b11
  } flag_sel_e;

  // Width of the selector, kept here so decoder and branch unit agree.
  localparam int unsigned FLAG_SEL_W = 2;

endpackage : kgp_risc_pkg

// File: rtl/branch_unit_if.sv
// Bundle of ALU flags, control decode and the registered branch decision.
interface branch_unit_if;
  import kgp_risc_pkg::*;

  logic      carry;
  logic      zero;
  logic      sign;
  flag_sel_e flag;
  logic      branch;
  logic      branch_type;
  logic      br_not_eq;
  logic      br_type;

  // Datapath/control side: drives flags and decode, observes the decision.
  modport master (
    output carry, zero, sign, flag, branch, branch_type, br_not_eq,
    input  br_type
  );

  // Branch unit side.
  modport slave (
    input  carry, zero, sign, flag, branch, branch_type, br_not_eq,
    output br_type
  );

endinterface : branch_unit_if

// File: rtl/branch_cond_sel.sv
// Flag mux plus polarity inversion; the reserved selector never branches.
module branch_cond_sel
  import kgp_risc_pkg::*;
(
  input  logic      carry_i,
  input  logic      zero_i,
  input  logic      sign_i,
  input  flag_sel_e flag_i,
  input  logic      br_not_eq_i,
  output logic      eff_o
);

  // Pick the selected flag and apply the branch-on-clear inversion; only the
  // selected flag reaches the output so other flags are true don't-cares.
  always_comb begin
    eff_o = 1'b0;
    case (flag_i)
      FLAG_SEL_CARRY: eff_o = carry_i ^ br_not_eq_i;
      FLAG_SEL_ZERO:  eff_o = zero_i  ^ br_not_eq_i;
      FLAG_SEL_SIGN:  eff_o = sign_i  ^ br_not_eq_i;
      FLAG_SEL_RSVD:  eff_o = 1'b0;
      default:        eff_o = 1'b0;
    endcase
  end

endmodule : branch_cond_sel

// File: rtl/branch_unit.sv
// Branch decision for PC select: gated condition, registered with one cycle latency.
module branch_unit
  import kgp_risc_pkg::*;
#(
  parameter logic RESET_TAKEN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  branch_unit_if.slave bus
);

  logic eff;
  logic br_type_d;
  logic br_type_q;

  branch_cond_sel u_cond_sel (
    .carry_i     (bus.carry),
    .zero_i      (bus.zero),
    .sign_i      (bus.sign),
    .flag_i      (bus.flag),
    .br_not_eq_i (bus.br_not_eq),
    .eff_o       (eff)
  );

  // Gate the condition: no branch -> not taken, jump -> taken, branch -> eff.
  always_comb begin
    br_type_d = 1'b0;
    if (bus.branch) begin
      if (bus.branch_type) begin
        br_type_d = eff;
      end else begin
        br_type_d = 1'b1;
      end
    end
  end

  // Decision register; reset wins over any branch request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_type_q <= RESET_TAKEN;
    end else begin
      br_type_q <= br_type_d;
    end
  end

  assign bus.br_type = br_type_q;

endmodule : branch_unit

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed literal cases plus random stream
// checked every cycle against a behavioural model.
module tb_branch_unit;
  import kgp_risc_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic exp_q;
  logic model_valid;

  branch_unit_if bus_if ();

  branch_unit #(.RESET_TAKEN(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural rule: no branch -> 0; jump -> 1; reserved -> 0; else flag != invert.
  function automatic logic ref_taken(input logic b, input logic bt, input logic bne,
                                     input logic [1:0] f, input logic c,
                                     input logic z, input logic s);
    logic [3:0] flags;
    flags = {1'b0, s, z, c};
    if (!b) return 1'b0;
    if (!bt) return 1'b1;
    if (f == 2'd3) return 1'b0;
    return flags[f] != bne;
  endfunction

  // Model register: what br_type must be after this edge.
  always @(posedge clk) begin
    exp_q <= rst ? 1'b0 : ref_taken(bus_if.branch, bus_if.branch_type, bus_if.br_not_eq,
                                    bus_if.flag, bus_if.carry, bus_if.zero, bus_if.sign);
    model_valid <= 1'b1;
  end

  // Every-cycle comparison of DUT against model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid === 1'b1) begin
      n_checks++;
      if (bus_if.br_type !== exp_q) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t br_type=%b expected=%b", $time, bus_if.br_type, exp_q);
      end
    end
  end

  task automatic drive(input logic r, input logic b, input logic bt, input logic bne,
                       input logic [1:0] f, input logic c, input logic z, input logic s);
    rst                = r;
    bus_if.branch      = b;
    bus_if.branch_type = bt;
    bus_if.br_not_eq   = bne;
    bus_if.flag        = flag_sel_e'(f);
    bus_if.carry       = c;
    bus_if.zero        = z;
    bus_if.sign        = s;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic required);
    n_checks++;
    if (bus_if.br_type !== required) begin
      n_fail++;
      $display("FAIL %s br_type=%b required=%b", name, bus_if.br_type, required);
    end else begin
      $display("ok   %s br_type=%b", name, bus_if.br_type);
    end
  endtask

  initial begin
    logic want;
    logic [1:0] rf;
    logic rr, rb, rbt, rbne, rc, rz, rs;
    n_checks    = 0;
    n_fail      = 0;
    model_valid = 1'b0;
    exp_q       = 1'b0;
    // 1. Reset with an unconditional jump pending.
    drive(1, 1, 0, 0, 2'b00, 0, 0, 0);
    tick(); chk("reset_hold0", 1'b0);
    tick(); chk("reset_hold1", 1'b0);
    tick(); chk("reset_hold2", 1'b0);
    drive(0, 1, 0, 0, 2'b00, 0, 0, 0);
    tick(); chk("post_reset_jump", 1'b1);
    // 2. Branch on set.
    drive(0, 1, 1, 0, 2'b00, 1, 0, 0); tick(); chk("set_carry", 1'b1);
    drive(0, 1, 1, 0, 2'b01, 0, 1, 0); tick(); chk("set_zero", 1'b1);
    drive(0, 1, 1, 0, 2'b10, 0, 0, 1); tick(); chk("set_sign", 1'b1);
    // 3. Branch on clear.
    drive(0, 1, 1, 1, 2'b00, 0, 0, 0); tick(); chk("clr_carry", 1'b1);
    drive(0, 1, 1, 1, 2'b01, 0, 0, 0); tick(); chk("clr_zero", 1'b1);
    drive(0, 1, 1, 1, 2'b10, 0, 0, 0); tick(); chk("clr_sign", 1'b1);
    drive(0, 1, 1, 1, 2'b00, 1, 0, 0); tick(); chk("clr_carry_set", 1'b0);
    drive(0, 1, 1, 1, 2'b01, 0, 1, 0); tick(); chk("clr_zero_set", 1'b0);
    drive(0, 1, 1, 1, 2'b10, 0, 0, 1); tick(); chk("clr_sign_set", 1'b0);
    // 4. Selector isolation.
    drive(0, 1, 1, 0, 2'b01, 1, 0, 1); tick(); chk("iso_base", 1'b0);
    drive(0, 1, 1, 0, 2'b01, 0, 0, 1); tick(); chk("iso_carry_tgl", 1'b0);
    drive(0, 1, 1, 0, 2'b01, 0, 0, 0); tick(); chk("iso_sign_tgl", 1'b0);
    // 5. Gating and reserved selector.
    drive(0, 0, 0, 1, 2'b00, 0, 0, 0); tick(); chk("gate_nobranch", 1'b0);
    drive(0, 0, 1, 0, 2'b00, 1, 1, 1); tick(); chk("gate_nobranch_flags", 1'b0);
    drive(0, 1, 0, 0, 2'b00, 0, 0, 0); tick(); chk("gate_jump", 1'b1);
    drive(0, 1, 1, 0, 2'b11, 1, 1, 1); tick(); chk("rsvd_bne0", 1'b0);
    drive(0, 1, 1, 1, 2'b11, 0, 0, 0); tick(); chk("rsvd_bne1", 1'b0);
    // 6. Back-to-back alternation, then reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      want = (i % 2 == 0);
      drive(0, 1, 1, 0, 2'b00, want, 0, 0);
      tick(); chk($sformatf("alt_%0d", i), want);
    end
    drive(1, 1, 0, 0, 2'b00, 0, 0, 0); tick(); chk("mid_reset", 1'b0);
    drive(0, 1, 0, 0, 2'b00, 0, 0, 0); tick(); chk("mid_reset_release", 1'b1);
    // Random stream, checked by the model comparator every cycle.
    for (int i = 0; i < 500; i++) begin
      rr   = ($urandom_range(0, 19) == 0);
      rb   = $urandom_range(0, 3) != 0;
      rbt  = $urandom_range(0, 3) != 0;
      rbne = 1'($urandom_range(0, 1));
      rf   = 2'($urandom_range(0, 3));
      rc   = 1'($urandom_range(0, 1));
      rz   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      drive(rr, rb, rbt, rbne, rf, rc, rz, rs);
      tick();
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_branch_unit

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Branch-decision block of the KGP-RISC datapath, sitting between the ALU flag outputs, the control unit and the PC-select mux.
- It combines the ALU status flags (carry, zero, sign) with control-unit decode signals (branch, branch_type, br_not_eq, flag selector).
- It produces a single branch-taken indication, br_type, which drives PC selection.
- The decision is registered: one cycle of latency, synchronous reset.

Parameters:
- RESET_TAKEN, 1'b0, value br_type takes during and after reset (must stay 0 in the standard build).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- carry  input  1  ALU carry flag.
- zero  input  1  ALU zero flag (result == 0).
- sign  input  1  ALU sign flag (result MSB).
- flag  input  2  condition selector: 00 carry, 01 zero, 10 sign, 11 reserved.
- branch  input  1  current instruction is a branch/jump.
- branch_type  input  1  1 = conditional branch, 0 = unconditional jump.
- br_not_eq  input  1  1 = invert the selected condition (branch on flag clear).
- br_type  output  1  registered branch-taken decision; 1 = load branch target into PC.

Behaviour:
- Combinational select:
  - cond = carry when flag=00, zero when flag=01, sign when flag=10.
  - cond = 0 when flag=11 (reserved).
- Polarity:
  - eff = cond XOR br_not_eq for flag 00/01/10.
  - For flag=11, eff = 0 regardless of br_not_eq. A reserved selector never branches.
- Decision:
  - branch=0 gives taken = 0, whatever branch_type, br_not_eq, flag or the flag inputs are.
  - branch=1, branch_type=0 gives taken = 1 (unconditional); flag, br_not_eq and the flag inputs are ignored.
  - branch=1, branch_type=1 gives taken = eff.
- Register: on each rising clk, br_type <= taken. Latency is exactly 1 cycle from input sample to output.
- Reset:
  - While rst=1 at a rising edge, br_type <= RESET_TAKEN (0). Reset takes priority over any branch request in the same cycle.
  - The first post-reset decision appears one cycle after rst deasserts, reflecting the inputs sampled at that edge.
- No internal state other than the br_type flop. No handshakes; inputs are sampled every cycle.
- All inputs must be known (no X) at the sampling edge. An X on an input selected by the current decode may propagate; unselected inputs must not affect br_type.
- Non-selected flags are don't-care. Example: a carry toggle while flag=01 must not change br_type.

Decomposition:
- Shared package, kgp_risc_pkg:
  - FLAG_SEL_CARRY=2'b00, FLAG_SEL_ZERO=2'b01, FLAG_SEL_SIGN=2'b10, FLAG_SEL_RSVD=2'b11.
  - A typedef for the 2-bit flag selector, shared with the control-unit decoder.
- Natural sub-module: branch_cond_sel, the purely combinational flag mux plus polarity inversion, producing eff.
- The top level adds the branch/branch_type gating and the output register.

Test Plan:
1. Reset: assert rst with branch=1, branch_type=0 -> br_type=0 at every edge while rst=1. Deassert rst -> br_type=1 one cycle later.
2. Branch on set:
   - carry=1, flag=00 -> br_type=1.
   - zero=1, flag=01 -> 1.
   - sign=1, flag=10 -> 1.
   - All with branch=1, branch_type=1, br_not_eq=0, each seen one cycle after applying.
3. Branch on clear: all flags=0, branch=1, branch_type=1, br_not_eq=1, flag stepping 00,01,10 -> br_type=1 each cycle. Same with the selected flag=1 -> br_type=0.
4. Selector isolation: flag=01, zero=0, carry=1, sign=1, br_not_eq=0, branch=1, branch_type=1 -> br_type=0. Toggling carry or sign keeps br_type at 0.
5. Gating:
   - branch=0, branch_type=0, br_not_eq=1, flags 0 -> br_type=0.
   - branch=1, branch_type=0, all flags 0, br_not_eq=0 -> br_type=1.
   - flag=11 with branch=1, branch_type=1 and br_not_eq in {0,1} -> br_type=0.
6. Latency and back-to-back: alternate taken/not-taken decisions every cycle -> br_type follows exactly one cycle behind, with no glitches or skipped cycles. Assert rst mid-stream -> br_type=0 at the next edge.
